// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the request/response handshake and the data-memory bus of the
// RV32I load/store unit.
//   slave  : the load/store unit side (takes requests, drives memory bus)
//   master : the requester / memory side (issues requests, returns read data)
// Signals:
//   i_req, i_isStore, i_funct3, i_address, i_storeData : request
//   o_ready, o_done, o_misaligned, o_loadData         : status / result
//   o_memAddress, o_memWriteEnable, o_memWriteData    : memory command
//   i_memReadData                                     : memory read data
interface load_store_unit_if;
    logic        i_req;
    logic        i_isStore;
    logic [2:0]  i_funct3;
    logic [31:0] i_address;
    logic [31:0] i_storeData;
    logic        o_ready;
    logic        o_done;
    logic        o_misaligned;
    logic [31:0] o_loadData;
    logic [31:0] o_memAddress;
    logic        o_memWriteEnable;
    logic [31:0] o_memWriteData;
    logic [31:0] i_memReadData;

    modport slave (
        input  i_req, i_isStore, i_funct3, i_address, i_storeData, i_memReadData,
        output o_ready, o_done, o_misaligned, o_loadData,
               o_memAddress, o_memWriteEnable, o_memWriteData
    );

    modport master (
        output i_req, i_isStore, i_funct3, i_address, i_storeData, i_memReadData,
        input  o_ready, o_done, o_misaligned, o_loadData,
               o_memAddress, o_memWriteEnable, o_memWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I load/store unit in front of a word-organised data memory with
// combinational read data. Loads read one word and extract/extend the
// addressed byte or half; sw writes directly; sb/sh perform a
// read-modify-write of the containing word. Misaligned or illegal
// accesses complete immediately with o_misaligned set and no memory write.
// Ports:
//   i_clk : clock, all state on rising edge
//   i_rst : synchronous active-high reset
//   bus   : load_store_unit_if.slave (request, result and memory bus)
module load_store_unit (
    input  logic             i_clk,
    input  logic             i_rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t      state_reg;
    logic [1:0]  addr_lo_reg;
    logic [2:0]  funct3_reg;
    logic        is_store_reg;
    logic [15:0] store_lo_reg;     // only the low half is needed for sb/sh merges
    logic        ready_reg;
    logic        done_reg;
    logic        misaligned_reg;
    logic        we_reg;
    logic [31:0] load_data_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] wdata_reg;

    logic        accept_fault;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_next;
    logic [31:0] merge_next;
    logic [3:0]  lane_en;

    // Fault classification of the request being offered in IDLE.
    always_comb begin
        accept_fault = 1'b0;
        case (bus.i_funct3)
            3'b011, 3'b110, 3'b111: accept_fault = 1'b1;
            default: ;
        endcase
        if (bus.i_isStore && bus.i_funct3[2]) begin
            accept_fault = 1'b1;
        end
        if ((bus.i_funct3[1:0] == 2'b01) && bus.i_address[0]) begin
            accept_fault = 1'b1;
        end
        if ((bus.i_funct3[1:0] == 2'b10) && (bus.i_address[1:0] != 2'b00)) begin
            accept_fault = 1'b1;
        end
    end

    // Little-endian extraction from the word currently on the read bus.
    always_comb begin
        sel_byte  = bus.i_memReadData[{addr_lo_reg, 3'b000} +: 8];
        sel_half  = addr_lo_reg[1] ? bus.i_memReadData[31:16] : bus.i_memReadData[15:0];
        load_next = bus.i_memReadData;
        case (funct3_reg[1:0])
            2'b00: load_next = funct3_reg[2] ? {24'b0, sel_byte}
                                             : {{24{sel_byte[7]}}, sel_byte};
            2'b01: load_next = funct3_reg[2] ? {16'b0, sel_half}
                                             : {{16{sel_half[15]}}, sel_half};
            default: load_next = bus.i_memReadData;
        endcase
    end

    // Read-modify-write merge for sb/sh: each byte lane either takes the
    // store data or keeps the word just read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] src_byte;

            assign lane_en[gi] = funct3_reg[0] ? (addr_lo_reg[1] == LANE[1])
                                               : (addr_lo_reg == LANE);
            // For sh the upper lane of each half takes store bits [15:8].
            assign src_byte = (funct3_reg[0] && LANE[0]) ? store_lo_reg[15:8]
                                                         : store_lo_reg[7:0];
            assign merge_next[gi*8 +: 8] = lane_en[gi] ? src_byte
                                                       : bus.i_memReadData[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            addr_lo_reg    <= 2'b00;
            funct3_reg     <= 3'b000;
            is_store_reg   <= 1'b0;
            store_lo_reg   <= 16'h0000;
            ready_reg      <= 1'b1;
            done_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            we_reg         <= 1'b0;
            load_data_reg  <= 32'h0;
            mem_addr_reg   <= 32'h0;
            wdata_reg      <= 32'h0;
        end else begin
            // Pulse-type outputs default low; only the transition into the
            // state that owns them raises them for exactly one cycle.
            done_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            we_reg         <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        addr_lo_reg  <= bus.i_address[1:0];
                        funct3_reg   <= bus.i_funct3;
                        is_store_reg <= bus.i_isStore;
                        store_lo_reg <= bus.i_storeData[15:0];
                        mem_addr_reg <= {bus.i_address[31:2], 2'b00};
                        ready_reg    <= 1'b0;
                        if (accept_fault) begin
                            state_reg      <= ST_FAULT;
                            done_reg       <= 1'b1;
                            misaligned_reg <= 1'b1;
                            load_data_reg  <= 32'h0;
                        end else if (bus.i_isStore && (bus.i_funct3 == 3'b010)) begin
                            // sw needs no read: the full word is known now.
                            state_reg <= ST_WRITE;
                            we_reg    <= 1'b1;
                            wdata_reg <= bus.i_storeData;
                        end else begin
                            state_reg <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (is_store_reg) begin
                        state_reg <= ST_WRITE;
                        we_reg    <= 1'b1;
                        wdata_reg <= merge_next;
                    end else begin
                        state_reg     <= ST_DONE;
                        done_reg      <= 1'b1;
                        load_data_reg <= load_next;
                    end
                end

                ST_WRITE: begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end

                ST_DONE, ST_FAULT: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready          = ready_reg;
    assign bus.o_done           = done_reg;
    assign bus.o_misaligned     = misaligned_reg;
    assign bus.o_loadData       = load_data_reg;
    assign bus.o_memAddress     = mem_addr_reg;
    // Gated so a reset arriving in the WRITE cycle never reaches memory.
    assign bus.o_memWriteEnable = we_reg & ~i_rst;
    assign bus.o_memWriteData   = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Data memory seen by the DUT (64 words, indexed by address bits [7:2]).
    logic [31:0] mem     [0:63];
    // Reference copy updated only by the behavioural model.
    logic [31:0] ref_mem [0:63];

    assign bus.i_memReadData = mem[bus.o_memAddress[7:2]];

    always @(posedge clk) begin
        if (bus.o_memWriteEnable) begin
            mem[bus.o_memAddress[7:2]] = bus.o_memWriteData;
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;
    logic [31:0] exp_load = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[a[7:2]]     = v;
        ref_mem[a[7:2]] = v;
    endtask

    task automatic randomize_inputs(input bit with_req);
        bus.i_req       = with_req ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_isStore   = 1'($urandom_range(0, 1));
        bus.i_funct3    = 3'($urandom_range(0, 7));
        bus.i_address   = $urandom;
        bus.i_storeData = $urandom;
    endtask

    // One access, starting at a negedge with the DUT idle; returns at a
    // negedge with the DUT idle again.
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input bit noise);
        logic        fault;
        int          lat;
        int          wr_exp;
        int          idx;
        int          sh;
        logic [31:0] word;
        logic [31:0] new_word;
        logic [31:0] ld;
        int          done_k;
        int          nwr;
        int          wr_k;
        logic [31:0] wr_data;
        logic        mis;
        logic        addr_ok;

        // Behavioural expectation straight from the access rules.
        idx      = int'(addr[7:2]);
        word     = ref_mem[idx];
        new_word = word;
        ld       = exp_load;
        wr_exp   = 0;
        fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]) ||
                ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        if (fault) begin
            lat = 1;
            ld  = 32'h0;
        end else if (st) begin
            if (f3 == 3'b010) begin
                new_word = data;
                lat      = 2;
                wr_exp   = 1;
            end else if (f3 == 3'b000) begin
                sh       = int'(addr[1:0]) * 8;
                new_word = (word & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
                lat      = 3;
                wr_exp   = 2;
            end else begin
                sh       = int'(addr[1]) * 16;
                new_word = (word & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
                lat      = 3;
                wr_exp   = 2;
            end
        end else begin
            lat = 2;
            case (f3)
                3'b000, 3'b100: begin
                    sh = int'(addr[1:0]) * 8;
                    ld = (word >> sh) & 32'hFF;
                    if (f3 == 3'b000 && ld[7]) ld = ld | 32'hFFFFFF00;
                end
                3'b001, 3'b101: begin
                    sh = int'(addr[1]) * 16;
                    ld = (word >> sh) & 32'hFFFF;
                    if (f3 == 3'b001 && ld[15]) ld = ld | 32'hFFFF0000;
                end
                default: ld = word;
            endcase
        end

        bus.i_req       = 1'b1;
        bus.i_isStore   = st;
        bus.i_funct3    = f3;
        bus.i_address   = addr;
        bus.i_storeData = data;

        done_k  = 0;
        nwr     = 0;
        wr_k    = 0;
        wr_data = 32'h0;
        mis     = 1'b0;
        addr_ok = 1'b1;
        for (int k = 1; k <= 8 && done_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_ready", 32'(bus.o_ready), 32'd0);
            if (bus.o_memAddress !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
            if (bus.o_memWriteEnable) begin
                nwr++;
                wr_k    = k;
                wr_data = bus.o_memWriteData;
            end
            if (bus.o_done) begin
                done_k = k;
                mis    = bus.o_misaligned;
            end else begin
                randomize_inputs(noise);
            end
        end
        bus.i_req = 1'b0;

        check("latency", 32'(done_k), 32'(lat));
        check("misaligned", 32'(mis), 32'(fault));
        check("mem_addr", 32'(addr_ok), 32'd1);
        check("write_count", 32'(nwr), (wr_exp != 0) ? 32'd1 : 32'd0);
        if (wr_exp != 0) begin
            check("write_cycle", 32'(wr_k), 32'(wr_exp));
            check("write_data", wr_data, new_word);
        end
        check("load_data", bus.o_loadData, ld);

        exp_load = ld;
        if (!fault && st) ref_mem[idx] = new_word;

        @(negedge clk);
        check("idle_ready", 32'(bus.o_ready), 32'd1);
        check("done_pulse", 32'(bus.o_done), 32'd0);
        txn++;
        $display("txn %0d st=%0d f3=%0d addr=%h data=%h fault=%0d lat=%0d load=%h",
                 txn, st, f3, addr, data, fault, done_k, bus.o_loadData);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_mis"}, 32'(bus.o_misaligned), 32'd0);
        check({tag, "_load"}, bus.o_loadData, 32'h0);
        check({tag, "_maddr"}, bus.o_memAddress, 32'h0);
        check({tag, "_we"}, 32'(bus.o_memWriteEnable), 32'd0);
        check({tag, "_wdata"}, bus.o_memWriteData, 32'h0);
    endtask

    initial begin
        int          dones;
        int          first_k;
        int          second_k;
        logic [31:0] b2b_load;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;

        for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
        rst = 1'b1;
        randomize_inputs(1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(bus.o_ready), 32'd1);

        // lw of a known word
        set_word(32'h10, 32'hDEADBEEF);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw_dead", bus.o_loadData, 32'hDEADBEEF);

        // sign vs zero extension
        set_word(32'h20, 32'h80FF7F01);
        do_access(1'b0, 3'b000, 32'h23, 32'h0, 1'b1);
        check("lb_23", bus.o_loadData, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h23, 32'h0, 1'b1);
        check("lbu_23", bus.o_loadData, 32'h00000080);
        do_access(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
        check("lh_22", bus.o_loadData, 32'hFFFF80FF);

        // sb read-modify-write
        set_word(32'h30, 32'h11223344);
        do_access(1'b1, 3'b000, 32'h31, 32'hAABBCCEE, 1'b1);
        check("sb_word", mem[12], 32'h1122EE44);

        // misaligned accesses
        do_access(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
        check("lw_fault_load", bus.o_loadData, 32'h0);
        do_access(1'b1, 3'b001, 32'h05, 32'h5555AAAA, 1'b0);
        check("sh_fault_load", bus.o_loadData, 32'h0);

        // reset during the WRITE cycle of sh
        set_word(32'h50, 32'hCAFEF00D);
        bus.i_req = 1'b1; bus.i_isStore = 1'b1; bus.i_funct3 = 3'b001;
        bus.i_address = 32'h52; bus.i_storeData = 32'h1234BEEF;
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("rst_pre_we", 32'(bus.o_memWriteEnable), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_we_gated", 32'(bus.o_memWriteEnable), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_write");
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        check("rst_mem_kept", mem[20], 32'hCAFEF00D);
        exp_load = 32'h0;
        $display("txn reset-in-write sh addr=00000052");

        // back-to-back with i_req held high
        bus.i_req = 1'b1; bus.i_isStore = 1'b1; bus.i_funct3 = 3'b010;
        bus.i_address = 32'h40; bus.i_storeData = 32'h12345678;
        dones = 0; first_k = 0; second_k = 0; b2b_load = 32'h0;
        for (int k = 1; k <= 12 && dones < 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_isStore = 1'b0; bus.i_funct3 = 3'b010;
                bus.i_address = 32'h40; bus.i_storeData = $urandom;
            end
            if (k == 3) check("b2b_idle_ready", 32'(bus.o_ready), 32'd1);
            if (bus.o_done) begin
                dones++;
                if (dones == 1) first_k = k;
                else begin
                    second_k = k;
                    b2b_load = bus.o_loadData;
                    bus.i_req = 1'b0;
                end
            end
        end
        bus.i_req = 1'b0;
        check("b2b_sw_done", 32'(first_k), 32'd2);
        check("b2b_lw_done", 32'(second_k), 32'd5);
        check("b2b_load", b2b_load, 32'h12345678);
        check("b2b_mem", mem[16], 32'h12345678);
        ref_mem[16] = 32'h12345678;
        exp_load    = 32'h12345678;
        @(negedge clk);
        $display("txn back-to-back sw/lw addr=00000040");

        // randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            do_access(st, f3, addr, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
